jtag_tap_target: RTL and testbench

- Parametrised JTAG TAP target model; the DUT-side responder for the JTAG AVIP master agent.
- Implements the full 16-state TAP controller, a configurable-width instruction register, and three data registers selected by instruction:
  - BYPASS
  - USER (test vector register)
  - BOUNDARY-SCAN
- Generalises the fixed 5-bit instruction and 8/16/24/32-bit vector widths of the global package into per-instance parameters.
- Exposes TAP state, decoded instruction and update strobes for scoreboard checking.

---
 rtl/jtag_tap_target.sv | 166 ++++++++++++++++
 tb/tb_jtag_tap_target.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_target.sv
// JTAG TAP target: 16-state TAP controller, parameterised IR, and BYPASS/USER/BSR
// data registers. TAP state, decoded instruction and update strobes are exposed for checking.
module jtag_tap_target #(
  parameter int IR_WIDTH      = 5,
  parameter int DR_WIDTH      = 32,
  parameter int BSR_WIDTH     = 16,
  parameter int BYPASS_OPCODE = 0,
  parameter int USER_OPCODE   = 1,
  parameter int BSR_OPCODE    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdoEnable,
  output logic [3:0]           tapState,
  output logic [IR_WIDTH-1:0]  instruction,
  input  logic [DR_WIDTH-1:0]  userDataIn,
  output logic [DR_WIDTH-1:0]  userDataOut,
  input  logic [BSR_WIDTH-1:0] bsrIn,
  output logic [BSR_WIDTH-1:0] bsrOut,
  output logic                 updateIrPulse,
  output logic                 updateDrPulse
);

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_IDLE   = 4'd1;
  localparam logic [3:0] S_SELDR  = 4'd2;
  localparam logic [3:0] S_SELIR  = 4'd3;
  localparam logic [3:0] S_CAPIR  = 4'd4;
  localparam logic [3:0] S_SHIR   = 4'd5;
  localparam logic [3:0] S_E1IR   = 4'd6;
  localparam logic [3:0] S_PIR    = 4'd7;
  localparam logic [3:0] S_E2IR   = 4'd8;
  localparam logic [3:0] S_UPIR   = 4'd9;
  localparam logic [3:0] S_CAPDR  = 4'd10;
  localparam logic [3:0] S_SHDR   = 4'd11;
  localparam logic [3:0] S_E1DR   = 4'd12;
  localparam logic [3:0] S_PDR    = 4'd13;
  localparam logic [3:0] S_E2DR   = 4'd14;
  localparam logic [3:0] S_UPDR   = 4'd15;

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(BYPASS_OPCODE);
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(USER_OPCODE);
  localparam logic [IR_WIDTH-1:0] OP_BSR    = IR_WIDTH'(BSR_OPCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [3:0]           state_q, state_d;
  logic [IR_WIDTH-1:0]  ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0]  instr_q, instr_d;
  logic [DR_WIDTH-1:0]  user_sr_q, user_sr_d;
  logic [DR_WIDTH-1:0]  user_out_q, user_out_d;
  logic [BSR_WIDTH-1:0] bsr_sr_q, bsr_sr_d;
  logic [BSR_WIDTH-1:0] bsr_out_q, bsr_out_d;
  logic                 byp_q, byp_d;
  logic                 sel_user, sel_bsr;

  // USER wins if both opcodes alias after truncation; everything else is bypass.
  assign sel_user = (instr_q == OP_USER);
  assign sel_bsr  = (instr_q == OP_BSR) && !sel_user;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = tms ? S_RESET : S_IDLE;
      S_IDLE:  state_d = tms ? S_SELDR : S_IDLE;
      S_SELDR: state_d = tms ? S_SELIR : S_CAPDR;
      S_SELIR: state_d = tms ? S_RESET : S_CAPIR;
      S_CAPIR: state_d = tms ? S_E1IR  : S_SHIR;
      S_SHIR:  state_d = tms ? S_E1IR  : S_SHIR;
      S_E1IR:  state_d = tms ? S_UPIR  : S_PIR;
      S_PIR:   state_d = tms ? S_E2IR  : S_PIR;
      S_E2IR:  state_d = tms ? S_UPIR  : S_SHIR;
      S_UPIR:  state_d = tms ? S_SELDR : S_IDLE;
      S_CAPDR: state_d = tms ? S_E1DR  : S_SHDR;
      S_SHDR:  state_d = tms ? S_E1DR  : S_SHDR;
      S_E1DR:  state_d = tms ? S_UPDR  : S_PDR;
      S_PDR:   state_d = tms ? S_E2DR  : S_PDR;
      S_E2DR:  state_d = tms ? S_UPDR  : S_SHDR;
      S_UPDR:  state_d = tms ? S_SELDR : S_IDLE;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    ir_sr_d    = ir_sr_q;
    instr_d    = instr_q;
    user_sr_d  = user_sr_q;
    user_out_d = user_out_q;
    bsr_sr_d   = bsr_sr_q;
    bsr_out_d  = bsr_out_q;
    byp_d      = byp_q;
    // Synchronous entry into Reset matches async reset but keeps the parallel outputs.
    if (state_d == S_RESET) begin
      ir_sr_d   = '0;
      instr_d   = OP_BYPASS;
      user_sr_d = '0;
      bsr_sr_d  = '0;
      byp_d     = 1'b0;
    end else begin
      case (state_q)
        S_CAPIR: ir_sr_d = IR_CAPTURE;
        S_SHIR:  ir_sr_d = (ir_sr_q >> 1) | (IR_WIDTH'(tdi) << (IR_WIDTH - 1));
        S_UPIR:  instr_d = ir_sr_q;
        S_CAPDR: begin
          if (sel_user)     user_sr_d = userDataIn;
          else if (sel_bsr) bsr_sr_d  = bsrIn;
          else              byp_d     = 1'b0;
        end
        S_SHDR: begin
          if (sel_user)     user_sr_d = (user_sr_q >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
          else if (sel_bsr) bsr_sr_d  = (bsr_sr_q >> 1) | (BSR_WIDTH'(tdi) << (BSR_WIDTH - 1));
          else              byp_d     = tdi;
        end
        S_UPDR: begin
          if (sel_user)     user_out_d = user_sr_q;
          else if (sel_bsr) bsr_out_d  = bsr_sr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RESET;
      ir_sr_q    <= '0;
      instr_q    <= OP_BYPASS;
      user_sr_q  <= '0;
      user_out_q <= '0;
      bsr_sr_q   <= '0;
      bsr_out_q  <= '0;
      byp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_sr_q    <= ir_sr_d;
      instr_q    <= instr_d;
      user_sr_q  <= user_sr_d;
      user_out_q <= user_out_d;
      bsr_sr_q   <= bsr_sr_d;
      bsr_out_q  <= bsr_out_d;
      byp_q      <= byp_d;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == S_SHIR) begin
      tdo = ir_sr_q[0];
    end else if (state_q == S_SHDR) begin
      if (sel_user)     tdo = user_sr_q[0];
      else if (sel_bsr) tdo = bsr_sr_q[0];
      else              tdo = byp_q;
    end
  end

  assign tdoEnable     = (state_q == S_SHIR) || (state_q == S_SHDR);
  assign tapState      = state_q;
  assign instruction   = instr_q;
  assign userDataOut   = user_out_q;
  assign bsrOut        = bsr_out_q;
  assign updateIrPulse = (state_q == S_UPIR);
  assign updateDrPulse = (state_q == S_UPDR);

endmodule

// File: tb/tb_jtag_tap_target.sv
// Scoreboard bench for jtag_tap_target: the driver pushes per-cycle, tdo and reset
// expectations; independent monitors pop and compare when the DUT presents them.
module tb_jtag_tap_target;
  localparam int IRW  = 5;
  localparam int DRW  = 32;
  localparam int BSRW = 16;

  localparam logic [3:0] S_RESET = 4'd0,  S_IDLE = 4'd1,  S_SELDR = 4'd2,  S_SELIR = 4'd3;
  localparam logic [3:0] S_CAPIR = 4'd4,  S_SHIR = 4'd5,  S_E1IR  = 4'd6,  S_UPIR  = 4'd9;
  localparam logic [3:0] S_CAPDR = 4'd10, S_SHDR = 4'd11, S_E1DR  = 4'd12, S_PDR   = 4'd13;
  localparam logic [3:0] S_E2DR  = 4'd14, S_UPDR = 4'd15;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            tms = 1'b1;
  logic            tdi = 1'b0;
  logic            tdo, tdoEnable;
  logic [3:0]      tapState;
  logic [IRW-1:0]  instruction;
  logic [DRW-1:0]  userDataIn, userDataOut;
  logic [BSRW-1:0] bsrIn, bsrOut;
  logic            updateIrPulse, updateDrPulse;

  jtag_tap_target dut (
    .clk(clk), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdoEnable(tdoEnable),
    .tapState(tapState), .instruction(instruction), .userDataIn(userDataIn),
    .userDataOut(userDataOut), .bsrIn(bsrIn), .bsrOut(bsrOut),
    .updateIrPulse(updateIrPulse), .updateDrPulse(updateDrPulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      st;
    logic [IRW-1:0]  instr;
    logic [DRW-1:0]  user;
    logic [BSRW-1:0] bsr;
  } cyc_t;

  cyc_t cyc_q[$];
  cyc_t rst_q[$];
  logic tdo_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [IRW-1:0]  cur_instr = '0;
  logic [DRW-1:0]  cur_user  = '0;
  logic [BSRW-1:0] cur_bsr   = '0;

  // Per-cycle monitor: state, instruction, parallel outputs and strobes.
  always @(negedge clk) begin : mon_cycle
    cyc_t e;
    logic irp, drp, ten;
    if (cyc_q.size() > 0) begin
      e   = cyc_q.pop_front();
      irp = (e.st == S_UPIR);
      drp = (e.st == S_UPDR);
      ten = (e.st == S_SHIR) || (e.st == S_SHDR);
      n_cmp++;
      if ({tapState, instruction, userDataOut, bsrOut, updateIrPulse, updateDrPulse, tdoEnable} !==
          {e.st, e.instr, e.user, e.bsr, irp, drp, ten}) begin
        n_err++;
        $display("FAIL cycle @%0t: got st=%0d ir=%h user=%h bsr=%h pir=%b pdr=%b en=%b, want st=%0d ir=%h user=%h bsr=%h pir=%b pdr=%b en=%b",
                 $time, tapState, instruction, userDataOut, bsrOut, updateIrPulse, updateDrPulse, tdoEnable,
                 e.st, e.instr, e.user, e.bsr, irp, drp, ten);
      end
    end
  end

  // tdo monitor: one expected bit per cycle the DUT drives tdo.
  always @(negedge clk) begin : mon_tdo
    logic b;
    if (tdoEnable === 1'b1) begin
      n_cmp++;
      if (tdo_q.size() == 0) begin
        n_err++;
        $display("FAIL tdo_unexpected @%0t: got tdo=%b, want no shift", $time, tdo);
      end else begin
        b = tdo_q.pop_front();
        if (tdo !== b) begin
          n_err++;
          $display("FAIL tdo @%0t: got %b, want %b", $time, tdo, b);
        end
      end
    end
  end

  // Async reset monitor: effects must be visible before any clock edge.
  always @(posedge reset) begin : mon_rst
    cyc_t e;
    #1;
    n_cmp++;
    if (rst_q.size() == 0) begin
      n_err++;
      $display("FAIL reset_unexpected @%0t", $time);
    end else begin
      e = rst_q.pop_front();
      if ({tapState, instruction, userDataOut, bsrOut, updateIrPulse, updateDrPulse, tdoEnable} !==
          {e.st, e.instr, e.user, e.bsr, 3'b000}) begin
        n_err++;
        $display("FAIL async_reset @%0t: got st=%0d ir=%h user=%h bsr=%h, want st=%0d ir=%h user=%h bsr=%h",
                 $time, tapState, instruction, userDataOut, bsrOut, e.st, e.instr, e.user, e.bsr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic t, input logic d, input logic [3:0] st,
                      input logic has_tdo, input logic exp_tdo);
    cyc_t e;
    @(negedge clk); #1;
    tms = t;
    tdi = d;
    @(posedge clk);
    if (st == S_RESET) cur_instr = '0;
    e.st = st; e.instr = cur_instr; e.user = cur_user; e.bsr = cur_bsr;
    cyc_q.push_back(e);
    if (has_tdo) tdo_q.push_back(exp_tdo);
  endtask

  task automatic async_reset();
    cyc_t e;
    e.st = S_RESET; e.instr = '0; e.user = '0; e.bsr = '0;
    rst_q.push_back(e);
    cur_instr = '0; cur_user = '0; cur_bsr = '0;
    tms = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    tick(1'b0, 1'b0, S_IDLE, 1'b0, 1'b0);
  endtask

  // From Idle: load opcode LSB first, expecting the 1,0,0.. capture pattern on tdo.
  task automatic ir_scan(input logic [IRW-1:0] op);
    tick(1, 0, S_SELDR, 0, 0);
    tick(1, 0, S_SELIR, 0, 0);
    tick(0, 0, S_CAPIR, 0, 0);
    tick(0, 0, S_SHIR, 1, 1'b1);
    for (int i = 0; i < IRW; i++) begin
      if (i < IRW - 1) tick(0, op[i], S_SHIR, 1, 1'b0);
      else             tick(1, op[i], S_E1IR, 0, 0);
    end
    tick(1, 0, S_UPIR, 0, 0);
    cur_instr = op;
    tick(0, 0, S_IDLE, 0, 0);
  endtask

  // From Idle: shift n bits of din, expecting cap on tdo; optional 3-cycle pause.
  task automatic dr_scan(input logic [63:0] din, input logic [63:0] cap, input int n,
                         input int pause_at, input int kind);
    tick(1, 0, S_SELDR, 0, 0);
    tick(0, 0, S_CAPDR, 0, 0);
    tick(0, 0, S_SHDR, 1, cap[0]);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        tick(1, din[i], S_E1DR, 0, 0);
      end else if (i == pause_at - 1) begin
        tick(1, din[i], S_E1DR, 0, 0);
        repeat (3) tick(0, 0, S_PDR, 0, 0);
        tick(1, 0, S_E2DR, 0, 0);
        tick(0, 0, S_SHDR, 1, cap[i+1]);
      end else begin
        tick(0, din[i], S_SHDR, 1, cap[i+1]);
      end
    end
    tick(1, 0, S_UPDR, 0, 0);
    if (kind == 1)      cur_user = din[DRW-1:0];
    else if (kind == 2) cur_bsr  = din[BSRW-1:0];
    tick(0, 0, S_IDLE, 0, 0);
  endtask

  initial begin
    logic [31:0] ud;
    userDataIn = 32'hA5A5_F00F;
    bsrIn      = 16'hBEEF;
    ud         = 32'hA5A5_F00F;
    #3;
    async_reset();

    ir_scan(5'b00001);
    dr_scan(64'h1234_5678, 64'hA5A5_F00F, 32, 0, 1);

    ir_scan(5'b00000);
    dr_scan(64'h0B, 64'h16, 5, 0, 0);

    ir_scan(5'd6);
    dr_scan(64'h00FF, 64'hBEEF, 16, 8, 2);

    // Reset between edges with 10 of 32 USER bits shifted.
    ir_scan(5'b00001);
    tick(1, 0, S_SELDR, 0, 0);
    tick(0, 0, S_CAPDR, 0, 0);
    tick(0, 0, S_SHDR, 1, ud[0]);
    for (int i = 0; i < 10; i++) tick(0, 1'b1, S_SHDR, 1, ud[i+1]);
    @(negedge clk); #1;
    async_reset();

    // Five TMS=1 cycles from ShiftDr; the exit edge still shifts a 0 in.
    ir_scan(5'b00001);
    tick(1, 0, S_SELDR, 0, 0);
    tick(0, 0, S_CAPDR, 0, 0);
    tick(0, 0, S_SHDR, 1, ud[0]);
    tick(1, 0, S_E1DR, 0, 0);
    tick(1, 0, S_UPDR, 0, 0);
    cur_user = 32'h52D2_F807;
    tick(1, 0, S_SELDR, 0, 0);
    tick(1, 0, S_SELIR, 0, 0);
    tick(1, 0, S_RESET, 0, 0);
    tick(1, 0, S_RESET, 0, 0);
    tick(0, 0, S_IDLE, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (cyc_q.size() != 0 || tdo_q.size() != 0 || rst_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got cyc=%0d tdo=%0d rst=%0d pending, want 0",
               cyc_q.size(), tdo_q.size(), rst_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
